// File: rtl/mem_stage.sv
// mem_stage: memory access stage of the pipeline.
// Holds the data RAM (synchronous read), a two-state load FSM that stalls
// upstream for one cycle per load, and the MEM/WB pipeline register.
// Optional feature: define MEM_STAGE_MMIO_LEDR_EN to map address 0xFFFFF020
// onto the 10-bit LED register; otherwise ledr is tied low and that address
// aliases into RAM like any other.
module mem_stage #(
  parameter int DBITS           = 32,
  parameter int DMEM_WORDS_BITS = 10,
  parameter int REG_BITS        = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                memtoReg_m,
  input  logic                memWrite_m,
  input  logic                jal_m,
  input  logic                regWrite_m,
  input  logic [DBITS-1:0]    incrementedPC_m,
  input  logic [DBITS-1:0]    aluOut_m,
  input  logic [DBITS-1:0]    sr2Out_m,
  input  logic [REG_BITS-1:0] dreg_m,
  output logic                stall,
  output logic                regWrite_w,
  output logic [REG_BITS-1:0] dreg_w,
  output logic [DBITS-1:0]    wbData_w,
  output logic [9:0]          ledr
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] LOAD_WAIT = 1'b1;
  localparam int         DEPTH     = 1 << DMEM_WORDS_BITS;

  logic [0:0]                 state;
  logic [DBITS-1:0]           dmem [DEPTH];
  logic [DBITS-1:0]           rdData;
  logic [DBITS-1:0]           loadData;
  logic [DMEM_WORDS_BITS-1:0] wordIdx;
  logic                       isStore;
  logic                       isLoad;
  logic                       ledrHit;
  logic                       ramWrite;

  // Word index: byte offset bits dropped, upper bits alias
  assign wordIdx = aluOut_m[DMEM_WORDS_BITS+1:2];

`ifdef MEM_STAGE_MMIO_LEDR_EN
  localparam logic [DBITS-1:0] LEDR_ADDR = DBITS'(32'hFFFFF020);
  logic [9:0] ledrReg;

  assign ledrHit = (aluOut_m == LEDR_ADDR);
  assign ledr    = ledrReg;

  // LED register: written by a store to its address while IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      ledrReg <= '0;
    end else if (state == IDLE && isStore && ledrHit) begin
      ledrReg <= sr2Out_m[9:0];
    end
  end

  // Inputs are held during LOAD_WAIT, so the decode still selects the source
  always_comb begin
    loadData = rdData;
    if (ledrHit) loadData = {{(DBITS-10){1'b0}}, ledrReg};
  end
`else
  assign ledrHit = 1'b0;
  assign ledr    = '0;

  // Load data always comes from RAM
  always_comb begin
    loadData = rdData;
  end
`endif

  // Decode: store wins over load, jal suppresses load; stall only on load issue
  always_comb begin
    isStore  = memWrite_m;
    isLoad   = memtoReg_m & ~memWrite_m & ~jal_m;
    stall    = ~reset & (state == IDLE) & isLoad;
    ramWrite = ~reset & (state == IDLE) & isStore & ~ledrHit;
  end

  // Data RAM: synchronous write and read, contents never reset
  always_ff @(posedge clk) begin
    if (ramWrite) dmem[wordIdx] <= sr2Out_m;
    rdData <= dmem[wordIdx];
  end

  // Load FSM and MEM/WB register
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      regWrite_w <= 1'b0;
      dreg_w     <= '0;
      wbData_w   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (isLoad) begin
            state      <= LOAD_WAIT;
            regWrite_w <= 1'b0;
            dreg_w     <= '0;
            wbData_w   <= '0;
          end else begin
            regWrite_w <= regWrite_m;
            dreg_w     <= dreg_m;
            wbData_w   <= jal_m ? incrementedPC_m : aluOut_m;
          end
        end
        LOAD_WAIT: begin
          state      <= IDLE;
          regWrite_w <= regWrite_m;
          dreg_w     <= dreg_m;
          wbData_w   <= loadData;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage with a transaction-level
// memory model (word array + LED register) and randomized traffic.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        memtoReg_m, memWrite_m, jal_m, regWrite_m;
  logic [31:0] incrementedPC_m, aluOut_m, sr2Out_m;
  logic [3:0]  dreg_m;
  logic        stall, regWrite_w;
  logic [3:0]  dreg_w;
  logic [31:0] wbData_w;
  logic [9:0]  ledr;

  int passed = 0;
  int total  = 0;

  logic [31:0] memModel [1024];
  logic [9:0]  ledrModel = '0;

  mem_stage #(.DBITS(32), .DMEM_WORDS_BITS(10), .REG_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .memtoReg_m(memtoReg_m), .memWrite_m(memWrite_m), .jal_m(jal_m),
    .regWrite_m(regWrite_m), .incrementedPC_m(incrementedPC_m),
    .aluOut_m(aluOut_m), .sr2Out_m(sr2Out_m), .dreg_m(dreg_m),
    .stall(stall), .regWrite_w(regWrite_w), .dreg_w(dreg_w),
    .wbData_w(wbData_w), .ledr(ledr)
  );

  always #5 clk = ~clk;

  function automatic int unsigned idxOf(input logic [31:0] a);
    return (a / 4) % 1024;
  endfunction

  function automatic bit isLedrAddr(input logic [31:0] a);
`ifdef MEM_STAGE_MMIO_LEDR_EN
    return a == 32'hFFFFF020;
`else
    return 1'b0;
`endif
  endfunction

  // Data a load from address a should return
  function automatic logic [31:0] loadVal(input logic [31:0] a);
    if (isLedrAddr(a)) return {22'b0, ledrModel};
    return memModel[idxOf(a)];
  endfunction

  // Store effect on the model
  task automatic modelStore(input logic [31:0] a, input logic [31:0] d);
    if (isLedrAddr(a)) ledrModel = d[9:0];
    else memModel[idxOf(a)] = d;
  endtask

  task automatic setIn(input logic mr, input logic mw, input logic j, input logic rw,
                       input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] sr2, input logic [3:0] dr);
    memtoReg_m = mr; memWrite_m = mw; jal_m = j; regWrite_m = rw;
    incrementedPC_m = pc; aluOut_m = alu; sr2Out_m = sr2; dreg_m = dr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    setIn(1, 0, 0, 1, 32'h0, 32'h40, 32'h0, 4'd2);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else passed++;
    tick(); tick();
    total++; if (regWrite_w !== 1'b0) $display("FAIL reset_regWrite: got %b want 0", regWrite_w); else passed++;
    total++; if (dreg_w !== 4'd0) $display("FAIL reset_dreg: got %0h want 0", dreg_w); else passed++;
    total++; if (wbData_w !== 32'd0) $display("FAIL reset_wbData: got %0h want 0", wbData_w); else passed++;
    total++; if (ledr !== 10'd0) $display("FAIL reset_ledr: got %0h want 0", ledr); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall2: got %b want 0", stall); else passed++;
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    setIn(0, 1, 0, 0, 0, 32'h10, 32'hDEADBEEF, 0);
    modelStore(32'h10, 32'hDEADBEEF);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL st_stall: got %b want 0", stall); else passed++;
    tick();
    setIn(1, 0, 0, 1, 0, 32'h10, 0, 4'd3);
    #1;
    total++; if (stall !== 1'b1) $display("FAIL ld_stall_issue: got %b want 1", stall); else passed++;
    tick();
    total++; if (stall !== 1'b0) $display("FAIL ld_stall_wait: got %b want 0", stall); else passed++;
    total++; if (regWrite_w !== 1'b0) $display("FAIL ld_bubble: got %b want 0", regWrite_w); else passed++;
    tick();
    total++; if (regWrite_w !== 1'b1) $display("FAIL ld_regWrite: got %b want 1", regWrite_w); else passed++;
    total++; if (dreg_w !== 4'd3) $display("FAIL ld_dreg: got %0d want 3", dreg_w); else passed++;
    total++; if (wbData_w !== 32'hDEADBEEF) $display("FAIL ld_data: got %h want deadbeef", wbData_w); else passed++;
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL ld_stall_after: got %b want 0", stall); else passed++;
  endtask

  task automatic test_alu();
    setIn(0, 0, 0, 1, 32'h0, 32'h1234, 32'h0, 4'd5);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL alu_stall: got %b want 0", stall); else passed++;
    tick();
    total++; if (wbData_w !== 32'h1234) $display("FAIL alu_data: got %h want 1234", wbData_w); else passed++;
    total++; if (regWrite_w !== 1'b1 || dreg_w !== 4'd5)
      $display("FAIL alu_ctl: got rw=%b dr=%0d want rw=1 dr=5", regWrite_w, dreg_w); else passed++;
  endtask

  task automatic test_jal();
    setIn(1, 0, 1, 1, 32'h204, 32'h10, 32'h0, 4'd7);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL jal_stall: got %b want 0", stall); else passed++;
    tick();
    total++; if (wbData_w !== 32'h204) $display("FAIL jal_data: got %h want 204", wbData_w); else passed++;
    total++; if (regWrite_w !== 1'b1) $display("FAIL jal_rw: got %b want 1", regWrite_w); else passed++;
  endtask

  task automatic test_back_to_back();
    setIn(0, 1, 0, 0, 0, 32'h0, 32'h11, 0); modelStore(32'h0, 32'h11); tick();
    setIn(0, 1, 0, 0, 0, 32'h4, 32'h22, 0); modelStore(32'h4, 32'h22); tick();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] a;
      a = 32'(k * 4);
      setIn(1, 0, 0, 1, 0, a, 0, 4'(k + 1));
      #1;
      total++; if (stall !== 1'b1) $display("FAIL b2b_stall%0d: got %b want 1", k, stall); else passed++;
      tick();
      total++; if (regWrite_w !== 1'b0) $display("FAIL b2b_bubble%0d: got %b want 0", k, regWrite_w); else passed++;
      tick();
      total++; if (wbData_w !== loadVal(a) || regWrite_w !== 1'b1)
        $display("FAIL b2b_data%0d: got %h rw=%b want %h rw=1", k, wbData_w, regWrite_w, loadVal(a)); else passed++;
    end
    total++; if (loadVal(32'h4) !== 32'h22) $display("FAIL b2b_model: got %h want 22", loadVal(32'h4)); else passed++;
  endtask

  task automatic test_reset_abort();
    setIn(1, 0, 0, 1, 0, 32'h10, 0, 4'd9);
    tick();
    total++; if (stall !== 1'b0) $display("FAIL abort_wait_stall: got %b want 0", stall); else passed++;
    reset = 1'b1;
    tick();
    total++; if (regWrite_w !== 1'b0 || wbData_w !== 32'd0)
      $display("FAIL abort_out: got rw=%b wb=%h want rw=0 wb=0", regWrite_w, wbData_w); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL abort_stall: got %b want 0", stall); else passed++;
    reset = 1'b0;
    setIn(0, 0, 0, 1, 0, 32'h55, 0, 4'd4);
    #1;
    total++; if (stall !== 1'b0) $display("FAIL abort_idle_stall: got %b want 0", stall); else passed++;
    tick();
    total++; if (wbData_w !== 32'h55 || dreg_w !== 4'd4)
      $display("FAIL abort_next: got wb=%h dr=%0d want wb=55 dr=4", wbData_w, dreg_w); else passed++;
  endtask

  task automatic test_mmio();
    setIn(0, 1, 0, 0, 0, 32'h20, 32'hA5A5, 0); modelStore(32'h20, 32'hA5A5); tick();
    setIn(0, 1, 0, 0, 0, 32'hFFFFF020, 32'h3FF, 0); modelStore(32'hFFFFF020, 32'h3FF); tick();
    total++; if (ledr !== ledrModel) $display("FAIL mmio_ledr: got %h want %h", ledr, ledrModel); else passed++;
    setIn(1, 0, 0, 1, 0, 32'h20, 0, 4'd6);
    tick(); tick();
    total++; if (wbData_w !== loadVal(32'h20)) $display("FAIL mmio_ram: got %h want %h", wbData_w, loadVal(32'h20)); else passed++;
    setIn(1, 0, 0, 1, 0, 32'hFFFFF020, 0, 4'd6);
    tick(); tick();
    total++; if (wbData_w !== loadVal(32'hFFFFF020)) $display("FAIL mmio_load: got %h want %h", wbData_w, loadVal(32'hFFFFF020)); else passed++;
    setIn(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    int unsigned wq[$];
    for (int i = 0; i < 300; i++) begin
      int unsigned kind;
      logic [31:0] a, d, pc;
      logic [3:0]  dr;
      logic        rw;
      kind = $urandom_range(0, 4);
      a = $urandom; d = $urandom; pc = $urandom; dr = 4'($urandom); rw = 1'($urandom);
      if (kind == 2 && wq.size() == 0) kind = 0;
      if (kind == 2) a = ($urandom & 32'hFFFFF003) | (wq[$urandom_range(0, wq.size() - 1)] << 2);
      case (kind)
        1, 4: setIn(kind == 4, 1, 0, rw, pc, a, d, dr);
        2:    setIn(1, 0, 0, rw, pc, a, d, dr);
        3:    setIn(1'($urandom), 0, 1, rw, pc, a, d, dr);
        default: setIn(0, 0, 0, rw, pc, a, d, dr);
      endcase
      #1;
      total++; if (stall !== (kind == 2)) $display("FAIL rnd_stall%0d: got %b want %b", i, stall, kind == 2); else passed++;
      if (kind == 1 || kind == 4) begin
        modelStore(a, d);
        if (!isLedrAddr(a)) wq.push_back(idxOf(a));
      end
      tick();
      if (kind == 2) begin
        total++; if (regWrite_w !== 1'b0 || dreg_w !== 4'd0 || wbData_w !== 32'd0)
          $display("FAIL rnd_bubble%0d: got rw=%b dr=%0d wb=%h want 0", i, regWrite_w, dreg_w, wbData_w); else passed++;
        tick();
      end
      total++; if (regWrite_w !== rw || dreg_w !== dr ||
                   wbData_w !== (kind == 2 ? loadVal(a) : (kind == 3 ? pc : a)))
        $display("FAIL rnd_wb%0d: got rw=%b dr=%0d wb=%h want rw=%b dr=%0d wb=%h", i, regWrite_w, dreg_w, wbData_w,
                 rw, dr, (kind == 2 ? loadVal(a) : (kind == 3 ? pc : a))); else passed++;
      total++; if (ledr !== ledrModel) $display("FAIL rnd_ledr%0d: got %h want %h", i, ledr, ledrModel); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_alu();
    test_jal();
    test_back_to_back();
    test_reset_abort();
    test_mmio();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DBITS, 32, data/address width.
REQ-002 Parameter DMEM_WORDS_BITS, 10, log2 of data RAM depth in 32-bit words.
REQ-003 Parameter REG_BITS, 4, destination register index width.
REQ-004 Port clk  in  1  sole clock; all state updates on posedge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Ports memtoReg_m, memWrite_m, jal_m, regWrite_m  in  1 each  control from the EX/MEM register.
REQ-007 Ports incrementedPC_m, aluOut_m, sr2Out_m  in  DBITS each  PC+4, effective address/ALU result, store data.
REQ-008 Port dreg_m  in  REG_BITS  destination register index.
REQ-009 Port stall  out  1  combinational; upstream holds the PC, IF/ID, ID/EX and EX/MEM registers while high.
REQ-010 Ports regWrite_w  out  1, dreg_w  out  REG_BITS, wbData_w  out  DBITS  registered MEM/WB outputs.
REQ-011 Port ledr  out  10  LED register (see Configuration).

Function
REQ-012 Data RAM SHALL hold 2^DMEM_WORDS_BITS words, indexed by aluOut_m[DMEM_WORDS_BITS+1:2]; aluOut_m[1:0] ignored (no misalignment trap); upper bits ignored (aliasing).
REQ-013 RAM read SHALL be synchronous, with read data available the cycle after the address is presented.
REQ-014 FSM states IDLE and LOAD_WAIT; reset state IDLE.
REQ-015 IDLE with memWrite_m=1: write sr2Out_m to RAM at posedge, stall=0, remain IDLE, MEM/WB captures regWrite_m/dreg_m/aluOut_m.
REQ-016 memWrite_m=1 with memtoReg_m=1 SHALL be treated as a store only; no load or stall occurs.
REQ-017 IDLE with memtoReg_m=1 and memWrite_m=0: present read address, stall=1, go to LOAD_WAIT, MEM/WB loads bubble (regWrite_w<=0, dreg_w<=0, wbData_w<=0).
REQ-018 LOAD_WAIT: stall=0; MEM/WB captures regWrite_m, dreg_m, RAM read data; return to IDLE.
REQ-019 Load-to-writeback latency SHALL be 2 cycles; non-load latency 1 cycle; throughput for back-to-back loads is one load per 2 cycles.
REQ-020 While stall=1 upstream holds all *_m inputs stable; mem_stage samples them in LOAD_WAIT unchanged.
REQ-021 Non-load wbData selection: jal_m=1 selects incrementedPC_m, otherwise aluOut_m; jal_m takes priority over memtoReg_m (no load started when jal_m=1).
REQ-022 No RAM write SHALL occur in LOAD_WAIT or during reset.
REQ-023 stall SHALL be 0 whenever reset=1.

Reset
REQ-024 With reset=1 at posedge: state<=IDLE, regWrite_w<=0, dreg_w<=0, wbData_w<=0, ledr<=0.
REQ-025 Reset in LOAD_WAIT SHALL abort the load; no writeback of that load occurs.
REQ-026 RAM contents SHALL NOT be reset.

Configuration
REQ-027 Macro MEM_STAGE_MMIO_LEDR_EN defined: address 0xFFFFF020 maps to ledr; store writes sr2Out_m[9:0] to ledr with no RAM write; load returns {22'b0, ledr} via the same 2-cycle LOAD_WAIT path.
REQ-028 Macro undefined: no address decode; 0xFFFFF020 aliases into RAM per REQ-012; ledr tied to 0.

Verification
REQ-029 Store aluOut_m=0x10, sr2Out_m=0xDEADBEEF, then load 0x10 with dreg_m=3 -> stall=1 for exactly one cycle; two cycles later regWrite_w=1, dreg_w=3, wbData_w=0xDEADBEEF.
REQ-030 ALU op aluOut_m=0x1234, regWrite_m=1 -> next cycle wbData_w=0x1234, stall never asserted.
REQ-031 jal_m=1, incrementedPC_m=0x204, memtoReg_m=1 -> next cycle wbData_w=0x204, no stall.
REQ-032 Back-to-back loads of 0x0 and 0x4 (holding 0x11, 0x22) -> wbData_w shows 0x11 then 0x22, with a bubble (regWrite_w=0) preceding each.
REQ-033 Assert reset in LOAD_WAIT -> next cycle state IDLE, regWrite_w=0, stall=0, no writeback of the aborted load.
REQ-034 With MEM_STAGE_MMIO_LEDR_EN, store 0x3FF to 0xFFFFF020 -> ledr=0x3FF, RAM word at index (0xFFFFF020>>2) mod 2^DMEM_WORDS_BITS unchanged; without the macro -> ledr=0 and that RAM word =0x3FF.
